// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//   Shares one single-port data memory between the CPU MEM stage and a host
//   loader/debug port. The CPU is served combinationally (zero added latency)
//   while the arbiter is IDLE. The host gets bounded bursts in the HOST state.
//   A starvation guard forces a host grant after MAX_WAIT consecutive losses.
//
// Handshake semantics:
//   cpu_req is served in any cycle where cpu_stall is low. While cpu_stall is
//   high the CPU must hold its request unchanged. host_req is held by the host
//   until granted. Every cycle with host_req & host_gnt is exactly one host
//   access. host_rvalid pulses for one cycle, the cycle after a host read,
//   with the data in host_rdata.
//
// Ports:
//   clock, reset          : clock and synchronous active-high reset
//   cpu_req/we/addr/wdata : CPU access request (MEM stage)
//   cpu_stall, cpu_rdata  : CPU hold, and read data passed straight through
//   host_req/we/addr/wdata: host access request
//   host_gnt              : high in the HOST state
//   host_rdata/rvalid     : registered host read data and its valid pulse
//   mem_addr/wdata/we     : memory port
//   mem_rdata             : combinational memory read data
//   stat_stall_cycles     : CPU stall cycle counter (zero unless stats are built)
//   stat_host_acc         : host access counter (zero unless stats are built)
//   dbg_state             : current arbiter state (0 = IDLE, 1 = HOST)
//
// Optional build macro: DMEM_ARB_STATS_EN enables the saturating statistics
// counters. Without it both stat ports are tied to zero.
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int MAX_BURST = 8,
  parameter int MAX_WAIT  = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_stall,
  output logic [DW-1:0] cpu_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic [DW-1:0] host_rdata,
  output logic          host_rvalid,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic [15:0]   stat_stall_cycles,
  output logic [15:0]   stat_host_acc,
  output logic          dbg_state
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOST = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [BW-1:0] r_burst_cnt;
  logic [BW-1:0] w_burst_nxt;
  logic [BW-1:0] w_burst_inc;
  logic [WW-1:0] r_wait_cnt;
  logic [WW-1:0] w_wait_nxt;
  logic [DW-1:0] r_host_rdata;
  logic          r_host_rvalid;
  logic          w_serve_cpu;
  logic          w_serve_host;

  // Exactly one requester can own the port: the CPU only in IDLE, the host
  // only in HOST.
  assign w_serve_cpu  = (r_state == ST_IDLE) && cpu_req;
  assign w_serve_host = (r_state == ST_HOST) && host_req;

  // The count after this cycle's host access. It saturates, so a host that is
  // never asked to yield keeps streaming.
  assign w_burst_inc = (r_burst_cnt >= BURST_MAX) ? BURST_MAX
                                                  : r_burst_cnt + BW'(1);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_burst_cnt <= '0;
      r_wait_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_burst_cnt <= w_burst_nxt;
      r_wait_cnt  <= w_wait_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_burst_nxt = r_burst_cnt;
    w_wait_nxt  = r_wait_cnt;
    case (r_state)
      ST_IDLE: begin
        if (host_req) begin
          if (!cpu_req) begin
            w_state_nxt = ST_HOST;
            w_wait_nxt  = '0;
          end else if (r_wait_cnt == WAIT_LAST) begin
            // Host has lost MAX_WAIT times in a row. The CPU is still served
            // this cycle, but the host owns the port from the next cycle.
            w_state_nxt = ST_HOST;
            w_wait_nxt  = '0;
          end else begin
            w_wait_nxt = r_wait_cnt + WW'(1);
          end
        end else begin
          w_wait_nxt = '0;
        end
      end
      ST_HOST: begin
        if (!host_req) begin
          w_state_nxt = ST_IDLE;
          w_burst_nxt = '0;
        end else if (cpu_req && (w_burst_inc >= BURST_MAX)) begin
          // The access in this cycle completes, then the CPU gets the port.
          w_state_nxt = ST_IDLE;
          w_burst_nxt = '0;
        end else begin
          w_burst_nxt = w_burst_inc;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_burst_nxt = '0;
        w_wait_nxt  = '0;
      end
    endcase
  end

  // Output logic. The strobes are gated with reset so that a reset arriving
  // mid-burst blocks the write in that very cycle.
  always_comb begin
    cpu_stall = 1'b0;
    host_gnt  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = host_addr;
    mem_wdata = host_wdata;
    if (w_serve_cpu) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
    if (!reset) begin
      host_gnt  = (r_state == ST_HOST);
      cpu_stall = (r_state == ST_HOST) && cpu_req;
      if (w_serve_cpu) begin
        mem_we = cpu_we;
      end else if (w_serve_host) begin
        mem_we = host_we;
      end
    end
  end

  // Host read data capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_host_rdata  <= '0;
      r_host_rvalid <= 1'b0;
    end else begin
      r_host_rvalid <= w_serve_host && !host_we;
      if (w_serve_host && !host_we) begin
        r_host_rdata <= mem_rdata;
      end
    end
  end

  assign cpu_rdata   = mem_rdata;
  assign host_rdata  = r_host_rdata;
  assign host_rvalid = r_host_rvalid;
  assign dbg_state   = r_state;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] r_stat_stall;
  logic [15:0] r_stat_host;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stat_stall <= '0;
      r_stat_host  <= '0;
    end else begin
      if (cpu_stall && (r_stat_stall != 16'hFFFF)) begin
        r_stat_stall <= r_stat_stall + 16'd1;
      end
      if (w_serve_host && (r_stat_host != 16'hFFFF)) begin
        r_stat_host <= r_stat_host + 16'd1;
      end
    end
  end

  assign stat_stall_cycles = r_stat_stall;
  assign stat_host_acc     = r_stat_host;
`else
  assign stat_stall_cycles = 16'd0;
  assign stat_host_acc     = 16'd0;
`endif

endmodule
